// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps illegal opcodes and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int ALUOP_W     = 2,
  parameter bit STICKY_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               branch,
  output logic               memread,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               alusrc,
  output logic               regwrite,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    ALU_WB   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t     state;
  state_t     nxt;
  logic       retire;
  logic [1:0] aluop2;
  logic       is_r;
  logic       is_i;
  logic       is_ld;
  logic       is_st;
  logic       is_br;

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_ld = (opcode == OP_LD);
  assign is_st = (opcode == OP_ST);
  assign is_br = (opcode == OP_BR);

  assign aluop   = ALUOP_W'(aluop2);
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Saturates at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (reset)
      instr_count <= '0;
    else if (retire && !(&instr_count))
      instr_count <= instr_count + CNT_W'(1);
  end

  always_comb begin
    nxt      = state;
    retire   = 1'b0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    branch   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    aluop2   = 2'b00;
    illegal  = 1'b0;
    unique case (state)
      IDLE: if (run) nxt = FETCH;
      FETCH: begin
        memread = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_r:          nxt = EXEC_R;
          is_i:          nxt = EXEC_I;
          is_ld | is_st: nxt = MEM_ADDR;
          is_br:         nxt = BRANCH;
          default:       nxt = TRAP;
        endcase
      end
      EXEC_R: begin
        aluop2 = 2'b10;
        nxt    = ALU_WB;
      end
      EXEC_I: begin
        alusrc = 1'b1;
        nxt    = ALU_WB;
      end
      ALU_WB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      // Opcode changing under us between DECODE and here is treated as illegal
      MEM_ADDR: begin
        alusrc = 1'b1;
        if (is_ld)      nxt = MEM_RD;
        else if (is_st) nxt = MEM_WR;
        else            nxt = TRAP;
      end
      MEM_RD: begin
        memread = 1'b1;
        alusrc  = 1'b1;
        if (mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      MEM_WR: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
        retire   = mem_ready;
      end
      BRANCH: begin
        branch = 1'b1;
        aluop2 = 2'b01;
        retire = 1'b1;
      end
      TRAP: begin
        illegal = 1'b1;
        if (!STICKY_TRAP) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (retire) nxt = run ? FETCH : IDLE;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction state sequences
// are generated from opcode and wait counts and checked cycle by cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       mem_ready;
  logic [6:0] opcode;

  wire [10:0] m_o, n_o, s_o;
  wire [31:0] m_cnt, n_cnt;
  wire [1:0]  s_cnt;
  wire [3:0]  m_st, n_st, s_st;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cnt = 0;
  bit          idle = 1'b1;

  localparam logic [6:0] OPS [5] = '{
    7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011
  };

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(m_o[10]), .ir_write(m_o[9]), .branch(m_o[8]),
    .memread(m_o[7]), .memwrite(m_o[6]), .memtoreg(m_o[5]),
    .alusrc(m_o[4]), .regwrite(m_o[3]), .aluop(m_o[2:1]),
    .illegal(m_o[0]), .instr_count(m_cnt), .state_o(m_st)
  );

  multicycle_control #(.STICKY_TRAP(1'b0)) u_ns (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(n_o[10]), .ir_write(n_o[9]), .branch(n_o[8]),
    .memread(n_o[7]), .memwrite(n_o[6]), .memtoreg(n_o[5]),
    .alusrc(n_o[4]), .regwrite(n_o[3]), .aluop(n_o[2:1]),
    .illegal(n_o[0]), .instr_count(n_cnt), .state_o(n_st)
  );

  multicycle_control #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(s_o[10]), .ir_write(s_o[9]), .branch(s_o[8]),
    .memread(s_o[7]), .memwrite(s_o[6]), .memtoreg(s_o[5]),
    .alusrc(s_o[4]), .regwrite(s_o[3]), .aluop(s_o[2:1]),
    .illegal(s_o[0]), .instr_count(s_cnt), .state_o(s_st)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Strobe table per state: {pc,ir,br,rd,wr,m2r,src,rw,aluop[1:0],ill}
  function automatic logic [10:0] exp_out(input int s, input logic mr);
    logic pc, ir, br, rd, wr, m2r, src, rw, ill;
    logic [1:0] op;
    {pc, ir, br, rd, wr, m2r, src, rw, ill} = '0;
    op = 2'b00;
    case (s)
      1:  begin rd = 1; pc = mr; ir = mr; end
      3:  op = 2'b10;
      4:  src = 1;
      5:  rw = 1;
      6:  src = 1;
      7:  begin rd = 1; src = 1; end
      8:  begin rw = 1; m2r = 1; end
      9:  begin wr = 1; src = 1; end
      10: begin br = 1; op = 2'b01; end
      11: ill = 1;
      default: ;
    endcase
    return {pc, ir, br, rd, wr, m2r, src, rw, op, ill};
  endfunction

  task automatic cyc(input int s, input logic mr, input logic rn,
                     input bit ret);
    mem_ready = mr;
    run       = rn;
    @(negedge clk);
    chk("state", 32'(m_st), 32'(s));
    chk("outs", 32'(m_o), 32'(exp_out(s, mr)));
    chk("count", m_cnt, cnt);
    chk("ns_state", 32'(n_st), 32'(s));
    chk("ns_outs", 32'(n_o), 32'(exp_out(s, mr)));
    chk("sat_state", 32'(s_st), 32'(s));
    chk("sat_outs", 32'(s_o), 32'(exp_out(s, mr)));
    chk("sat_count", 32'(s_cnt), (cnt > 3) ? 32'd3 : 32'(cnt));
    @(posedge clk);
    #1;
    if (ret) cnt++;
  endtask

  task automatic run_instr(input int k, input int wf, input int wm,
                           input logic ra);
    if (idle) cyc(0, 1'($urandom), 1'b1, 0);
    opcode = OPS[k];
    repeat (wf) cyc(1, 1'b0, 1'($urandom), 0);
    cyc(1, 1'b1, 1'($urandom), 0);
    cyc(2, 1'($urandom), 1'($urandom), 0);
    case (k)
      0: begin
        cyc(3, 1'($urandom), 1'($urandom), 0);
        cyc(5, 1'($urandom), ra, 1);
      end
      1: begin
        cyc(4, 1'($urandom), 1'($urandom), 0);
        cyc(5, 1'($urandom), ra, 1);
      end
      2: begin
        cyc(6, 1'($urandom), 1'($urandom), 0);
        repeat (wm) cyc(7, 1'b0, 1'($urandom), 0);
        cyc(7, 1'b1, 1'($urandom), 0);
        cyc(8, 1'($urandom), ra, 1);
      end
      3: begin
        cyc(6, 1'($urandom), 1'($urandom), 0);
        repeat (wm) cyc(9, 1'b0, 1'($urandom), 0);
        cyc(9, 1'b1, ra, 1);
      end
      default: cyc(10, 1'($urandom), ra, 1);
    endcase
    idle = !ra;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) cyc(0, 1'($urandom), 1'b0, 0);

    run_instr(0, 0, 0, 1'b1);
    run_instr(2, 0, 3, 1'b1);
    run_instr(3, 0, 0, 1'b1);
    run_instr(4, 0, 0, 1'b0);
    run_instr(1, 2, 0, 1'b0);
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(4)), int'($urandom_range(3)),
                int'($urandom_range(3)), 1'($urandom));
    chk("sat_final", 32'(s_cnt), 32'd3);

    // Reset while a load is stalled waiting on memory
    if (idle) cyc(0, 1'b1, 1'b1, 0);
    opcode = OPS[2];
    cyc(1, 1'b1, 1'b0, 0);
    cyc(2, 1'b1, 1'b0, 0);
    cyc(6, 1'b1, 1'b0, 0);
    cyc(7, 1'b0, 1'b0, 0);
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(m_st), 32'd0);
    chk("rst_memread", 32'(m_o[7]), 32'd0);
    chk("rst_count", m_cnt, 32'd0);
    chk("rst_outs", 32'(m_o), 32'd0);
    reset = 1'b0;
    cnt = 0;
    @(posedge clk);
    #1;
    cyc(0, 1'b0, 1'b0, 0);

    // Illegal opcode: sticky trap vs one-cycle pulse
    opcode = 7'b1111111;
    cyc(0, 1'b0, 1'b1, 0);
    cyc(1, 1'b1, 1'b0, 0);
    cyc(2, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      chk("trap_state", 32'(m_st), 32'd11);
      chk("trap_illegal", 32'(m_o[0]), 32'd1);
      chk("ns_state", 32'(n_st), (i == 0) ? 32'd11 : 32'd0);
      chk("ns_illegal", 32'(n_o[0]), (i == 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("trap_rst_state", 32'(m_st), 32'd0);
    chk("trap_rst_illegal", 32'(m_o[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
